// File: rtl/rf_pkg.sv
// Shared constants and helpers for the multi-port integer register file.
// Port k of a packed multi-port bus occupies bits [port_lo(k, w) +: w].
package rf_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;
    localparam int ZERO_ADDR = 0;

    function automatic int port_lo(input int k, input int w);
        return k * w;
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Busy-bit scoreboard: tracks registers with an issued-but-not-written producer,
// keeps a registered population count and answers per-read-port busy lookups.
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int NREGS    = NREGS_DEF,
    parameter int NRD      = 2,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1,
    parameter int AW       = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic              iss_en,
    input  logic [AW-1:0]     iss_addr,
    input  logic              flush,
    input  logic [NRD*AW-1:0] rd_addr,
    output logic [NRD-1:0]    rd_busy,
    output logic [AW:0]       pend_cnt
);

    localparam logic [AW-1:0] ZERO_A = ZERO_ADDR[AW-1:0];

    logic [NREGS-1:0] busy_q, busy_d;
    logic [AW:0]      pend_cnt_q, pend_cnt_d;

    // Issue is applied after writeback so a new producer wins over the retiring one.
    always_comb begin
        busy_d = busy_q;
        if (flush) begin
            busy_d = '0;
        end else begin
            if (wr_en)  busy_d[wr_addr]  = 1'b0;
            if (iss_en) busy_d[iss_addr] = 1'b1;
        end
        if (ZERO_REG) busy_d[ZERO_ADDR] = 1'b0;

        pend_cnt_d = '0;
        for (int r = 0; r < NREGS; r++) begin
            pend_cnt_d = pend_cnt_d + {{AW{1'b0}}, busy_d[r]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q     <= '0;
            pend_cnt_q <= '0;
        end else begin
            busy_q     <= busy_d;
            pend_cnt_q <= pend_cnt_d;
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_port
        logic [AW-1:0] addr;
        assign addr = rd_addr[port_lo(k, AW) +: AW];
        assign rd_busy[k] = busy_q[addr]
                          && !(BYPASS && wr_en && (wr_addr == addr))
                          && !(ZERO_REG && (addr == ZERO_A));
    end

    assign pend_cnt = pend_cnt_q;

endmodule

// File: rtl/regfile_mp_sb.sv
// Integer register file: one writeback port, NRD combinational read ports with
// optional writeback bypass and hardwired x0, plus an integrated busy scoreboard.
module regfile_mp_sb
    import rf_pkg::*;
#(
    parameter int XLEN     = XLEN_DEF,
    parameter int NREGS    = NREGS_DEF,
    parameter int NRD      = 2,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1,
    parameter int AW       = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en,
    input  logic [AW-1:0]       wr_addr,
    input  logic [XLEN-1:0]     wr_data,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic                iss_en,
    input  logic [AW-1:0]       iss_addr,
    input  logic                flush,
    output logic                stall,
    output logic [AW:0]         pend_cnt
);

    localparam logic [AW-1:0] ZERO_A = ZERO_ADDR[AW-1:0];

    logic [XLEN-1:0] mem_q [NREGS];
    logic [XLEN-1:0] mem_d [NREGS];
    logic            wr_ok;

    assign wr_ok = wr_en && !(ZERO_REG && (wr_addr == ZERO_A));

    always_comb begin
        mem_d = mem_q;
        if (wr_ok) mem_d[wr_addr] = wr_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NREGS; r++) mem_q[r] <= '0;
        end else begin
            mem_q <= mem_d;
        end
    end

    // Read priority: hardwired zero, then same-cycle writeback, then stored value.
    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] rdata;
        assign addr = rd_addr[port_lo(k, AW) +: AW];
        always_comb begin
            rdata = mem_q[addr];
            if (BYPASS && wr_en && (wr_addr == addr)) rdata = wr_data;
            if (ZERO_REG && (addr == ZERO_A)) rdata = '0;
        end
        assign rd_data[port_lo(k, XLEN) +: XLEN] = rdata;
    end

    rf_scoreboard #(
        .NREGS    (NREGS),
        .NRD      (NRD),
        .ZERO_REG (ZERO_REG),
        .BYPASS   (BYPASS),
        .AW       (AW)
    ) u_sb (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .flush    (flush),
        .rd_addr  (rd_addr),
        .rd_busy  (rd_busy),
        .pend_cnt (pend_cnt)
    );

    assign stall = |rd_busy;

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Bench for regfile_mp_sb: a bypassing and a non-bypassing instance share stimulus
// and are compared against an array-based reference model every cycle.
module tb_regfile_mp_sb;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [9:0]  rd_addr;
    logic        iss_en;
    logic [4:0]  iss_addr;
    logic        flush;

    logic [63:0] rd_data_b, rd_data_n;
    logic [1:0]  rd_busy_b, rd_busy_n;
    logic        stall_b, stall_n;
    logic [5:0]  pend_b, pend_n;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] m_reg  [32];
    bit          m_busy [32];

    always #5 clk = ~clk;

    regfile_mp_sb #(.BYPASS(1'b1)) dut_b (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
        .iss_en(iss_en), .iss_addr(iss_addr), .flush(flush),
        .stall(stall_b), .pend_cnt(pend_b)
    );

    regfile_mp_sb #(.BYPASS(1'b0)) dut_n (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr(rd_addr), .rd_data(rd_data_n), .rd_busy(rd_busy_n),
        .iss_en(iss_en), .iss_addr(iss_addr), .flush(flush),
        .stall(stall_n), .pend_cnt(pend_n)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_rd(input bit bp, input int a);
        if (a == 0) return 32'h0;
        if (bp && wr_en && (int'(wr_addr) == a)) return wr_data;
        return m_reg[a];
    endfunction

    function automatic bit exp_busy(input bit bp, input int a);
        if (a == 0) return 1'b0;
        if (bp && wr_en && (int'(wr_addr) == a)) return 1'b0;
        return m_busy[a];
    endfunction

    function automatic int exp_pend();
        int c = 0;
        for (int r = 0; r < 32; r++) c += int'(m_busy[r]);
        return c;
    endfunction

    task automatic check_outputs();
        bit sb = 1'b0;
        bit sn = 1'b0;
        for (int k = 0; k < 2; k++) begin
            int a = int'(rd_addr[k*5 +: 5]);
            check_eq($sformatf("rd_data%0d_bp a=%0d", k, a), 64'(rd_data_b[k*32 +: 32]), 64'(exp_rd(1'b1, a)));
            check_eq($sformatf("rd_data%0d_nb a=%0d", k, a), 64'(rd_data_n[k*32 +: 32]), 64'(exp_rd(1'b0, a)));
            check_eq($sformatf("rd_busy%0d_bp a=%0d", k, a), 64'(rd_busy_b[k]), 64'(exp_busy(1'b1, a)));
            check_eq($sformatf("rd_busy%0d_nb a=%0d", k, a), 64'(rd_busy_n[k]), 64'(exp_busy(1'b0, a)));
            sb |= exp_busy(1'b1, a);
            sn |= exp_busy(1'b0, a);
        end
        check_eq("stall_bp", 64'(stall_b), 64'(sb));
        check_eq("stall_nb", 64'(stall_n), 64'(sn));
        check_eq("pend_bp", 64'(pend_b), 64'(exp_pend()));
        check_eq("pend_nb", 64'(pend_n), 64'(exp_pend()));
    endtask

    task automatic model_update();
        if (rst) begin
            for (int r = 0; r < 32; r++) begin
                m_reg[r]  = 32'h0;
                m_busy[r] = 1'b0;
            end
        end else begin
            if (wr_en && wr_addr != 5'd0) m_reg[wr_addr] = wr_data;
            if (flush) begin
                for (int r = 0; r < 32; r++) m_busy[r] = 1'b0;
            end else begin
                if (wr_en) m_busy[wr_addr] = 1'b0;
                if (iss_en && iss_addr != 5'd0) m_busy[iss_addr] = 1'b1;
            end
        end
    endtask

    task automatic idle();
        rst = 1'b0; wr_en = 1'b0; iss_en = 1'b0; flush = 1'b0;
    endtask

    task automatic rd(input logic [4:0] a0, input logic [4:0] a1);
        rd_addr = {a1, a0};
    endtask

    task automatic step();
        #1;
        check_outputs();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic write(input logic [4:0] a, input logic [31:0] d);
        idle(); wr_en = 1'b1; wr_addr = a; wr_data = d; step();
    endtask

    task automatic issue(input logic [4:0] a);
        idle(); iss_en = 1'b1; iss_addr = a; step();
    endtask

    initial begin
        idle();
        wr_addr = '0; wr_data = '0; iss_addr = '0; rd_addr = '0;
        rst = 1'b1;
        @(posedge clk);
        model_update();
        #1;
        idle();

        // Reset after random writes and issues
        for (int i = 0; i < 8; i++) begin
            idle();
            wr_en = 1'b1; wr_addr = 5'($urandom); wr_data = $urandom;
            iss_en = 1'b1; iss_addr = 5'($urandom);
            step();
        end
        idle(); rst = 1'b1; step();
        idle();
        for (int r = 0; r < 32; r++) begin
            rd(5'(r), 5'(31 - r));
            #1;
            check_eq($sformatf("reset_rd r%0d", r), 64'(rd_data_b[31:0]), 64'h0);
            check_outputs();
        end
        check_eq("reset_stall", 64'(stall_b), 64'h0);
        check_eq("reset_pend", 64'(pend_b), 64'h0);

        // Write/read and x0
        write(5'd12, 32'hDEADBEEF);
        write(5'd0, 32'h12345678);
        idle(); rd(5'd12, 5'd0); #1;
        check_eq("x12_read", 64'(rd_data_b[31:0]), 64'hDEADBEEF);
        check_eq("x0_read", 64'(rd_data_b[63:32]), 64'h0);
        check_outputs();

        // Bypass vs no bypass
        write(5'd5, 32'h1);
        idle(); wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hCAFEF00D; rd(5'd5, 5'd12); #1;
        check_eq("bypass_bp", 64'(rd_data_b[31:0]), 64'hCAFEF00D);
        check_eq("bypass_nb", 64'(rd_data_n[31:0]), 64'h1);
        step();

        // Scoreboard set and writeback clear
        issue(5'd7);
        idle(); rd(5'd7, 5'd0); #1;
        check_eq("sb_busy", 64'(rd_busy_b[0]), 64'h1);
        check_eq("sb_stall", 64'(stall_b), 64'h1);
        check_eq("sb_pend1", 64'(pend_b), 64'h1);
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h77; #1;
        check_eq("sb_wb_busy_bp", 64'(rd_busy_b[0]), 64'h0);
        check_eq("sb_wb_busy_nb", 64'(rd_busy_n[0]), 64'h1);
        step();
        idle(); #1;
        check_eq("sb_pend0", 64'(pend_b), 64'h0);

        // Same-cycle issue and writeback
        issue(5'd9);
        idle(); iss_en = 1'b1; iss_addr = 5'd9; wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'hA5A50009;
        step();
        idle(); rd(5'd9, 5'd9); #1;
        check_eq("iw_data", 64'(rd_data_b[31:0]), 64'hA5A50009);
        check_eq("iw_busy", 64'(rd_busy_b[0]), 64'h1);
        check_eq("iw_pend", 64'(pend_b), 64'h1);
        check_outputs();
        idle(); flush = 1'b1; step();
        issue(5'd0);
        idle(); #1;
        check_eq("iss_x0_pend", 64'(pend_b), 64'h0);

        // Flush and reset mid-operation
        write(5'd3, 32'h33); write(5'd4, 32'h44); write(5'd5, 32'h55);
        issue(5'd3); issue(5'd4); issue(5'd5);
        idle(); #1;
        check_eq("fl_pend3", 64'(pend_b), 64'h3);
        idle(); flush = 1'b1; iss_en = 1'b1; iss_addr = 5'd6; step();
        idle(); rd(5'd3, 5'd6); #1;
        check_eq("fl_pend0", 64'(pend_b), 64'h0);
        check_eq("fl_data", 64'(rd_data_b[31:0]), 64'h33);
        check_eq("fl_busy6", 64'(rd_busy_b[1]), 64'h0);
        check_outputs();
        issue(5'd3); issue(5'd4); issue(5'd5);
        idle(); rst = 1'b1; iss_en = 1'b1; iss_addr = 5'd6; step();
        idle(); rd(5'd3, 5'd6); #1;
        check_eq("rst_pend0", 64'(pend_b), 64'h0);
        check_eq("rst_data", 64'(rd_data_b[31:0]), 64'h0);
        check_outputs();

        // Randomized traffic over a small address pool to force collisions
        for (int i = 0; i < 600; i++) begin
            logic [4:0] pool;
            idle();
            pool     = 5'($urandom_range(0, 3) == 0 ? $urandom : $urandom_range(0, 7));
            rst      = ($urandom_range(0, 59) == 0);
            flush    = ($urandom_range(0, 14) == 0);
            wr_en    = $urandom_range(0, 1) == 1;
            wr_addr  = pool;
            wr_data  = $urandom;
            iss_en   = $urandom_range(0, 2) != 0;
            iss_addr = 5'($urandom_range(0, 1) == 1 ? $urandom_range(0, 7) : $urandom);
            rd($urandom_range(0, 2) == 0 ? wr_addr : 5'($urandom_range(0, 9)), 5'($urandom));
            step();
        end
        idle(); #1;
        check_outputs();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/regfile_mp_sb.md
Name: regfile_mp_sb

Overview:
Parametrised successor to the CPU integer register file: one writeback port, NRD combinational read ports, optional write-to-read bypass, optional hardwired-zero register 0, and an integrated busy-bit scoreboard. Sits between decode/issue (reads, destination reservation) and writeback. Decode uses it to stall on RAW hazards in the pipelined core.

Parameters:
XLEN, 32, data width in bits.
NREGS, 32, number of architectural registers (power of two, >=2).
NRD, 2, number of read ports (1..4).
ZERO_REG, 1, 1 = register 0 reads 0, ignores writes, never busy.
BYPASS, 1, 1 = same-cycle writeback data forwarded to read ports and clears busy on the read path.
AW, $clog2(NREGS), address width (derived; not overridden).

Ports:
clk  in  1  clock, all state updates on rising edge.
rst  in  1  reset, synchronous, active-high.
wr_en  in  1  writeback enable.
wr_addr  in  AW  writeback destination.
wr_data  in  XLEN  writeback data.
rd_addr  in  NRD*AW  read addresses; port k at bits [k*AW +: AW].
rd_data  out  NRD*XLEN  read data; port k at bits [k*XLEN +: XLEN].
rd_busy  out  NRD  per-port: addressed register has a pending write.
iss_en  in  1  reserve a destination (instruction issued).
iss_addr  in  AW  destination being reserved.
flush  in  1  clear all busy bits (pipeline flush); register contents kept.
stall  out  1  OR of rd_busy over all ports.
pend_cnt  out  AW+1  number of registers currently busy.

Behaviour:
- Reset (rst=1 at posedge): all NREGS registers <= 0, all busy bits <= 0, pend_cnt <= 0. rst overrides wr_en, iss_en and flush in the same cycle. Reset must be asserted for a clock edge to take effect. Outputs are combinational from state, so after reset rd_data=0, rd_busy=0, stall=0, pend_cnt=0.
- Write: at posedge, if wr_en and not (ZERO_REG and wr_addr==0), then reg[wr_addr] <= wr_data.
- Read: combinational, zero latency.
  - rd_data[k] = 0 if ZERO_REG and addr==0.
  - Else wr_data if BYPASS and wr_en and wr_addr==addr.
  - Else reg[addr].
- Busy set/clear at posedge, per register r. Priority, highest first:
  - rst clears.
  - flush clears all, including a same-cycle iss_en.
  - iss_en and iss_addr==r sets; wins over a same-cycle writeback to r, because the new producer is pending.
  - wr_en and wr_addr==r clears.
  - Otherwise hold.
- ZERO_REG=1: busy[0] is constant 0, and iss_en to register 0 is ignored.
- rd_busy[k]: busy[addr] and not (BYPASS and wr_en and wr_addr==addr). Forced 0 for register 0 when ZERO_REG=1.
- pend_cnt: registered population count of busy, updated with busy at the same edge.
  - Maximum value is NREGS (or NREGS-1 when ZERO_REG=1); the AW+1 width never wraps.
  - Re-issuing an already-busy register does not change the count.
- Writeback to a non-busy register is legal: data written, busy unaffected.
- Simultaneous iss_en and wr_en to the same address: data written, busy=1 afterwards, pend_cnt counts it once.
- No simulation-only print statements in the RTL.

Decomposition:
- Package rf_pkg: XLEN/NREGS defaults, ZERO_ADDR constant, read-port slice helper functions.
- Sub-module rf_scoreboard: busy vector, set/clear priority, pend_cnt, and per-port rd_busy lookup. Parametrised by NREGS, NRD, ZERO_REG, BYPASS.
- Storage array and read/bypass muxing stay in the top.

Test Plan:
- Reset then read: rst=1 for 1 cycle after random writes -> every register reads 0x00000000; rd_busy=0, stall=0, pend_cnt=0.
- Write/read and x0: write 0xDEADBEEF to r12, then 0x12345678 to r0 -> next cycle rd_addr0=12 gives 0xDEADBEEF; rd_addr1=0 gives 0x00000000.
- Bypass: reg r5=0x1, and in the same cycle wr_en with r5=0xCAFEF00D while rd_addr0=5 -> rd_data0=0xCAFEF00D combinationally. With BYPASS=0, rd_data0=0x1.
- Scoreboard: iss r7 -> next cycle rd_addr0=7 gives rd_busy0=1, stall=1, pend_cnt=1. Then wr_en r7 -> same cycle rd_busy0=0 (BYPASS=1); next cycle pend_cnt=0.
- Same-cycle issue+writeback r9 (busy) -> r9 holds new data, stays busy, pend_cnt unchanged. Iss r0 -> pend_cnt stays 0.
- Flush/reset mid-operation: busy r3, r4, r5 (pend_cnt=3), then flush together with iss r6 -> all busy 0, pend_cnt=0, data intact. Repeat with rst instead -> data also 0.
